// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared types and constants for the load/store unit: the
//             three-state control FSM encoding and the default request
//             timeout used when LSU_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Control FSM: idle, memory request outstanding, register write-back
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } lsu_state_t;

  // Default number of REQ cycles allowed before a request is abandoned
  localparam int LSU_TMO_DEFAULT = 16;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_timer.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_timer
//  Brief    : REQ-cycle counter for the load/store unit. Cleared when a new
//             request is issued, counts every cycle 'en' is high, and flags
//             'expired' during the TMO-th counted cycle so the FSM can give up
//             at the end of that cycle if no ack arrived.
//             Only instantiated when LSU_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_timer
  import lsu_pkg::*;
#(
  parameter int TMO = LSU_TMO_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Wide enough to hold TMO-1; the count saturates there
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  logic [CW-1:0] cnt;

  // Counter value during REQ cycle n is n-1, so expiry marks REQ cycle TMO
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CW'(TMO - 1));

endmodule : lsu_timer
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : Single-outstanding load/store engine between a core and a byte
//             wide data memory. Latches one request, holds it on the memory
//             port until acknowledged, and for loads writes the returned byte
//             into the register file one cycle later.
//             Optional feature: define LSU_TIMEOUT_EN to abandon a request
//             that is not acknowledged within TMO REQ cycles (err + done
//             pulse, no register write). Without it, REQ waits forever and
//             err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int pw  = 4,
  parameter int aw  = 8,
  parameter int TMO = LSU_TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_load,
  input  logic [aw-1:0] mem_addr,
  input  logic [7:0]    st_data,
  input  logic [pw-1:0] dest_reg,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          dm_req,
  output logic          dm_we,
  output logic [aw-1:0] dm_addr,
  output logic [7:0]    dm_wdata,
  input  logic [7:0]    dm_rdata,
  input  logic          dm_ack,
  output logic          rf_wr_en,
  output logic [pw-1:0] rf_wr_addr,
  output logic [7:0]    rf_dat
);

  lsu_state_t state, state_nxt;

  // Request captured at issue time; held stable for the whole operation
  logic          ld_q;
  logic [aw-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic [pw-1:0] dest_q;
  logic [7:0]    rdata_q;

  // Stores and timeouts finish from IDLE, so their done pulse is registered
  logic          done_q;

  logic          accept;    // start taken in IDLE
  logic          ack_take;  // ack honoured in REQ
  logic          tmo_hit;   // request abandoned this cycle
  logic          tmo_expired;

`ifdef LSU_TIMEOUT_EN
  logic err_q;

  lsu_timer #(
    .TMO (TMO)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (state == REQ),
    .expired (tmo_expired)
  );

  // err accompanies the done pulse of an abandoned request
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= tmo_hit;
    end
  end

  assign err = err_q;
`else
  assign tmo_expired = 1'b0;
  assign err         = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; an ack wins over expiry in the final allowed cycle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ack_take  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (dm_ack) begin
          ack_take  = 1'b1;
          state_nxt = ld_q ? WB : IDLE;
        end else if (tmo_expired) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WB: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, load-data capture and registered completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dest_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        ld_q    <= is_load;
        addr_q  <= mem_addr;
        wdata_q <= st_data;
        dest_q  <= dest_reg;
      end
      if (ack_take && ld_q) begin
        rdata_q <= dm_rdata;
      end
      done_q <= (ack_take && !ld_q) || tmo_hit;
    end
  end

  // Outputs decoded from registered state only
  assign busy       = (state != IDLE);
  assign done       = (state == WB) || done_q;
  assign dm_req     = (state == REQ);
  assign dm_we      = (state == REQ) && !ld_q;
  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign rf_wr_en   = (state == WB);
  assign rf_wr_addr = dest_q;
  assign rf_dat     = rdata_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Directed self-checking bench for load_store_unit. Cycle n is
//             the interval after the n-th rising edge following the issue
//             cycle (cycle 0); inputs and checks happen 1 ns after each edge.
//             Timeout scenarios run when LSU_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int PW  = 4;
  localparam int AW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          is_load;
  logic [AW-1:0] mem_addr;
  logic [7:0]    st_data;
  logic [PW-1:0] dest_reg;
  logic          busy;
  logic          done;
  logic          err;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [7:0]    dm_wdata;
  logic [7:0]    dm_rdata;
  logic          dm_ack;
  logic          rf_wr_en;
  logic [PW-1:0] rf_wr_addr;
  logic [7:0]    rf_dat;

  int passed = 0;
  int total  = 0;

  load_store_unit #(
    .pw  (PW),
    .aw  (AW),
    .TMO (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_load    (is_load),
    .mem_addr   (mem_addr),
    .st_data    (st_data),
    .dest_reg   (dest_reg),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ack     (dm_ack),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_dat     (rf_dat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic ld, input logic [7:0] a, input logic [7:0] d, input logic [3:0] r);
    start    = 1'b1;
    is_load  = ld;
    mem_addr = a;
    st_data  = d;
    dest_reg = r;
  endtask

  initial begin
    logic seen;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; mem_addr = '0;
    st_data = '0; dest_reg = '0; dm_rdata = '0; dm_ack = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", dm_req, 0);
    chk("rst_wen", rf_wr_en, 0);
    reset = 1'b0;
    tick();

    // Load, zero wait
    issue(1'b1, 8'h20, 8'h00, 4'd3);
    tick();                                   // cycle 1
    start = 1'b0;
    chk("ld0_req", dm_req, 1);
    chk("ld0_we", dm_we, 0);
    chk("ld0_addr", dm_addr, 8'h20);
    chk("ld0_busy", busy, 1);
    dm_ack = 1'b1; dm_rdata = 8'hA5;
    tick();                                   // cycle 2
    dm_ack = 1'b0; dm_rdata = 8'h00;
    chk("ld0_wen", rf_wr_en, 1);
    chk("ld0_waddr", rf_wr_addr, 3);
    chk("ld0_dat", rf_dat, 8'hA5);
    chk("ld0_done", done, 1);
    chk("ld0_req_off", dm_req, 0);
    tick();                                   // cycle 3
    chk("ld0_wen_one", rf_wr_en, 0);
    chk("ld0_done_one", done, 0);
    chk("ld0_idle", busy, 0);

    // Store, ack in cycle 3
    issue(1'b0, 8'h10, 8'h5C, 4'd0);
    tick();                                   // cycle 1
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("st_req", dm_req, 1);
      chk("st_we", dm_we, 1);
      chk("st_addr", dm_addr, 8'h10);
      chk("st_wdata", dm_wdata, 8'h5C);
      chk("st_wen", rf_wr_en, 0);
      chk("st_done_early", done, 0);
      if (c == 3) dm_ack = 1'b1;
      tick();
    end
    dm_ack = 1'b0;                            // cycle 4
    chk("st_done", done, 1);
    chk("st_wen4", rf_wr_en, 0);
    chk("st_req_off", dm_req, 0);
    chk("st_we_off", dm_we, 0);
    chk("st_busy", busy, 0);
    tick();
    chk("st_done_one", done, 0);

    // Ack outside REQ is ignored
    dm_ack = 1'b1; dm_rdata = 8'hEE;
    tick();
    dm_ack = 1'b0;
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_wen", rf_wr_en, 0);
    chk("stray_ack_done", done, 0);

    // Start while busy is ignored
    issue(1'b1, 8'h30, 8'h00, 4'd5);
    tick();                                   // cycle 1
    issue(1'b1, 8'h40, 8'h00, 4'd7);
    tick();                                   // cycle 2
    start = 1'b0;
    chk("busy_addr", dm_addr, 8'h30);
    dm_ack = 1'b1; dm_rdata = 8'h3C;
    tick();                                   // cycle 3
    dm_ack = 1'b0;
    chk("busy_wen", rf_wr_en, 1);
    chk("busy_waddr", rf_wr_addr, 5);
    chk("busy_dat", rf_dat, 8'h3C);
    tick();
    chk("busy_no_second", busy, 0);
    tick();
    chk("busy_no_second_wr", rf_wr_en, 0);

    // Reset mid-REQ with a simultaneous ack
    issue(1'b1, 8'h44, 8'h00, 4'd2);
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    reset = 1'b1; dm_ack = 1'b1; dm_rdata = 8'h77;
    tick();                                   // cycle 3
    reset = 1'b0; dm_ack = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_req", dm_req, 0);
    chk("mrst_we", dm_we, 0);
    chk("mrst_addr", dm_addr, 0);
    chk("mrst_wdata", dm_wdata, 0);
    chk("mrst_wen", rf_wr_en, 0);
    chk("mrst_waddr", rf_wr_addr, 0);
    chk("mrst_dat", rf_dat, 0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rf_wr_en || done) seen = 1'b1;
    end
    chk("mrst_no_late", seen, 0);

    // Store then start in its done cycle, then start in the cycle after done
    issue(1'b0, 8'h11, 8'h99, 4'd0);
    tick();                                   // cycle 1
    start = 1'b0;
    dm_ack = 1'b1;
    tick();                                   // cycle 2: store done, IDLE
    dm_ack = 1'b0;
    chk("b2b_st_done", done, 1);
    issue(1'b1, 8'h22, 8'h00, 4'd9);
    tick();                                   // cycle 3
    start = 1'b0;
    chk("b2b_ld1_req", dm_req, 1);
    chk("b2b_ld1_we", dm_we, 0);
    chk("b2b_ld1_addr", dm_addr, 8'h22);
    dm_ack = 1'b1; dm_rdata = 8'hC3;
    tick();                                   // cycle 4: WB
    dm_ack = 1'b0;
    chk("b2b_ld1_wen", rf_wr_en, 1);
    chk("b2b_ld1_waddr", rf_wr_addr, 9);
    chk("b2b_ld1_dat", rf_dat, 8'hC3);
    issue(1'b0, 8'h55, 8'h66, 4'd4);           // ignored: busy in WB
    tick();                                   // cycle 5
    chk("b2b_wb_start_ign", busy, 0);
    issue(1'b1, 8'h33, 8'h00, 4'd1);
    tick();                                   // cycle 6
    start = 1'b0;
    chk("b2b_ld2_addr", dm_addr, 8'h33);
    chk("b2b_ld2_we", dm_we, 0);
    dm_ack = 1'b1; dm_rdata = 8'h0F;
    tick();                                   // cycle 7
    dm_ack = 1'b0;
    chk("b2b_ld2_wen", rf_wr_en, 1);
    chk("b2b_ld2_waddr", rf_wr_addr, 1);
    chk("b2b_ld2_dat", rf_dat, 8'h0F);
    chk("b2b_ld2_done", done, 1);
    tick();

`ifdef LSU_TIMEOUT_EN
    // No ack: request held for TMO REQ cycles then abandoned
    issue(1'b1, 8'h70, 8'h00, 4'd6);
    tick();
    start = 1'b0;
    seen = 1'b1;
    for (int c = 1; c <= TMO; c++) begin
      if (!dm_req || err || done) seen = 1'b0;
      tick();
    end
    chk("tmo_req_held", seen, 1);
    chk("tmo_req_drop", dm_req, 0);
    chk("tmo_err", err, 1);
    chk("tmo_done", done, 1);
    chk("tmo_wen", rf_wr_en, 0);
    chk("tmo_busy", busy, 0);
    tick();
    chk("tmo_err_one", err, 0);
    chk("tmo_done_one", done, 0);

    // Ack on the last allowed REQ cycle is accepted
    issue(1'b1, 8'h71, 8'h00, 4'd8);
    tick();
    start = 1'b0;
    for (int c = 1; c < TMO; c++) tick();
    chk("tmo_last_req", dm_req, 1);
    dm_ack = 1'b1; dm_rdata = 8'hB4;
    tick();
    dm_ack = 1'b0;
    chk("tmo_last_wen", rf_wr_en, 1);
    chk("tmo_last_dat", rf_dat, 8'hB4);
    chk("tmo_last_err", err, 0);
    tick();
`else
    // Without the timeout, REQ waits indefinitely
    issue(1'b1, 8'h70, 8'h00, 4'd6);
    tick();
    start = 1'b0;
    seen = 1'b1;
    for (int c = 0; c < 3 * TMO; c++) begin
      if (!dm_req || err || done) seen = 1'b0;
      tick();
    end
    chk("wait_req_held", seen, 1);
    dm_ack = 1'b1; dm_rdata = 8'hB4;
    tick();
    dm_ack = 1'b0;
    chk("wait_wen", rf_wr_en, 1);
    chk("wait_dat", rf_dat, 8'hB4);
    chk("wait_err", err, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter pw, 4: register-file address width.
REQ-002 Parameter aw, 8: data-memory address width.
REQ-003 Parameter TMO, 16: timeout limit in REQ cycles (used only with LSU_TIMEOUT_EN).
REQ-004 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-005 Ports SHALL be as follows:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- start  in  1  issue pulse, sampled only when busy=0
- is_load  in  1  1=load, 0=store
- mem_addr  in  aw  memory address
- st_data  in  8  store data
- dest_reg  in  pw  load destination register
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse
- dm_req  out  1  memory request
- dm_we  out  1  memory write enable
- dm_addr  out  aw  memory address
- dm_wdata  out  8  memory write data
- dm_rdata  in  8  memory read data, valid with dm_ack
- dm_ack  in  1  memory acknowledge
- rf_wr_en  out  1  register-file write enable
- rf_wr_addr  out  pw  register-file write address
- rf_dat  out  8  register-file write data

Function
REQ-006 The FSM SHALL have three states: IDLE, REQ and WB.
REQ-007 In IDLE with start=1, the block SHALL latch is_load, mem_addr, st_data and dest_reg, and enter REQ on the next edge.
REQ-008 start SHALL be ignored whenever busy=1; busy=1 in REQ and WB.
REQ-009 In REQ:
- dm_req=1.
- dm_we=~is_load.
- dm_addr and dm_wdata SHALL come from latched values and stay stable until ack.
REQ-010 In REQ with dm_ack=1 (including the first REQ cycle):
- Load: capture dm_rdata and go to WB.
- Store: go to IDLE and pulse done on the following cycle.
REQ-011 In WB:
- rf_wr_en=1 for exactly one cycle.
- rf_wr_addr=latched dest_reg.
- rf_dat=captured data.
- done=1.
- Return to IDLE.
REQ-012 Latency, with start in cycle 0 and ack in cycle k≥1: done (and rf_wr_en for a load) SHALL be asserted in cycle k+1.
REQ-013 dm_ack outside REQ SHALL be ignored.
REQ-014 Outside REQ, dm_req=0 and dm_we=0; outside WB, rf_wr_en=0.
REQ-015 A start in the same cycle done=1 SHALL be accepted only if the state is IDLE. In WB, busy=1, so a start in that cycle is ignored.
REQ-016 Stores SHALL never assert rf_wr_en.

Reset
REQ-017 Reset SHALL force IDLE and clear every output to 0: busy, done, err, dm_req, dm_we, dm_addr, dm_wdata, rf_wr_en, rf_wr_addr, rf_dat.
REQ-018 Reset mid-operation SHALL abort without a register write or done pulse. A dm_ack arriving in the reset cycle SHALL be discarded.

Configuration
REQ-019 With macro LSU_TIMEOUT_EN defined:
- A counter SHALL count REQ cycles.
- An ack in REQ cycles 1..TMO SHALL be accepted.
- With no ack after TMO REQ cycles, the block SHALL drop dm_req, return to IDLE, and pulse err and done together on the next cycle, with no register write.
- The counter SHALL clear on entry to REQ.
REQ-020 Without LSU_TIMEOUT_EN, REQ SHALL wait indefinitely, err SHALL be tied 0, and no timeout counter logic SHALL exist.

Structure
REQ-021 Package lsu_pkg SHALL hold the FSM state enum (IDLE, REQ, WB) and the default TMO constant.
REQ-022 The timeout counter SHALL be sub-module lsu_timer (inputs clr, en; output expired), instantiated only under LSU_TIMEOUT_EN.

Verification
REQ-023 Load, zero-wait: start, is_load=1, mem_addr=0x20, dest_reg=3; ack in cycle 1 with dm_rdata=0xA5 -> cycle 2: rf_wr_en=1, rf_wr_addr=3, rf_dat=0xA5, done=1.
REQ-024 Store, 3-cycle wait: start, is_load=0, mem_addr=0x10, st_data=0x5C; ack in cycle 3 -> dm_req=1, dm_we=1, dm_wdata=0x5C held cycles 1-3; done=1 in cycle 4; rf_wr_en never 1.
REQ-025 Start while busy: second start with dest_reg=7 during a pending load -> ignored; only the first load's register is written.
REQ-026 Reset mid-REQ: assert reset in cycle 2 of a load, with dm_ack=1 in the same cycle -> all outputs 0 in cycle 3; no rf_wr_en or done afterwards.
REQ-027 Timeout (LSU_TIMEOUT_EN, TMO=16): no ack -> dm_req drops after 16 REQ cycles; err=done=1 for one cycle; no write. Repeat with ack on REQ cycle 16 -> accepted normally.
REQ-028 Back-to-back: a new start issued in the cycle after done -> second operation completes with correct, independent data.
